// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// Used by the arbiter, its interface and the bench.
package led_arb_pkg;

  localparam int LED_W    = 8;
  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  function automatic logic [MAX_NREQ-1:0] onehot(
    input logic [2:0] idx
  );
    logic [MAX_NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Bundle between pattern sources and the LED bank arbiter.
// master = source side, slave = arbiter side.
interface led_bank_arbiter_if #(
  parameter int NREQ = 4
) ();
  import led_arb_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*LED_W-1:0] pat;
  logic [NREQ-1:0]       gnt;
  logic [LED_W-1:0]      led;
  logic                  tick;
  logic                  busy;

  modport master (
    output req,
    output pat,
    input  gnt,
    input  led,
    input  tick,
    input  busy
  );

  modport slave (
    input  req,
    input  pat,
    output gnt,
    output led,
    output tick,
    output busy
  );

endinterface

// File: rtl/led_tick_gen.sv
// Free-running display-tick prescaler: one-cycle tick
// every PRESCALE clocks, registered.
module led_tick_gen #(
  parameter int PRESCALE = 15_000_000
) (
  input  logic clk100mhz,
  input  logic rst,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] presc_cnt;

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= (presc_cnt == PW'(PRESCALE-1));
      if (presc_cnt == PW'(PRESCALE-1))
        presc_cnt <= '0;
      else
        presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sliced sharing of one 8-LED bank
// among NREQ pattern sources.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int              NREQ         = 4,
  parameter int              PRESCALE     = 15_000_000,
  parameter int              SLOT_TICKS   = 4,
  parameter logic [LED_W-1:0] IDLE_PATTERN = 8'h00
) (
  input logic              clk100mhz,
  input logic              rst,
  led_bank_arbiter_if.slave bus
);

  localparam int OW = $clog2(NREQ);
  localparam int SW = $clog2(SLOT_TICKS+1);

  arb_state_t       state;
  logic [OW-1:0]    owner;
  logic [OW-1:0]    last;
  logic [OW-1:0]    pick;
  logic [SW-1:0]    slot_cnt;
  logic             tick;
  logic             any;
  logic             slot_end;
  logic             drop;
  logic [LED_W-1:0] owner_pat;

  led_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk100mhz (clk100mhz),
    .rst       (rst),
    .tick      (tick)
  );

  assign bus.tick = tick;
  assign any      = |bus.req;

  // Scan from farthest to nearest so last+1 wins the overwrite.
  always_comb begin
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req[OW'((int'(last) + k) % NREQ)])
        pick = OW'((int'(last) + k) % NREQ);
    end
  end

  assign owner_pat = bus.pat[int'(owner)*LED_W +: LED_W];
  assign drop      = !bus.req[owner];
  assign slot_end  = tick && (slot_cnt == SW'(SLOT_TICKS-1));

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      last     <= OW'(NREQ-1);
      slot_cnt <= '0;
      bus.gnt  <= '0;
      bus.busy <= 1'b0;
      bus.led  <= IDLE_PATTERN;
    end else begin
      unique case (state)
        IDLE: begin
          bus.led  <= IDLE_PATTERN;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          if (any) begin
            owner    <= pick;
            bus.gnt  <= NREQ'(onehot(3'(pick)));
            bus.busy <= 1'b1;
            slot_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          bus.led <= owner_pat;
          if (tick)
            slot_cnt <= slot_cnt + 1'b1;
          if (drop || slot_end) begin
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
            last     <= owner;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (any) begin
            owner    <= pick;
            bus.gnt  <= NREQ'(onehot(3'(pick)));
            bus.busy <= 1'b1;
            slot_cnt <= '0;
            state    <= GRANT;
          end else begin
            bus.led <= IDLE_PATTERN;
            state   <= IDLE;
          end
        end
        default: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the single 8-LED bank among NREQ pattern sources (counters, chasers, status displays) using round-robin time slices.
- Each source raises req and presents an 8-bit pattern. The arbiter grants one source at a time for at most SLOT_TICKS display ticks and drives the LEDs from the granted pattern.
- Contains the display-tick prescaler, so sources can use its tick to step their patterns in lock-step with the slot timing.
- Sits between the pattern generators and the board LED pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PRESCALE, 15_000_000, clk100mhz cycles per display tick (>=2).
- SLOT_TICKS, 4, maximum ticks one owner holds the bank (>=1).
- IDLE_PATTERN, 8'h00, LED value when no owner.

Ports:
- clk100mhz  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-source request, level.
- pat  in  NREQ*8  per-source pattern; source i occupies bits [8i+7:8i].
- gnt  out  NREQ  one-hot grant, registered.
- led  out  8  LED drive, registered; bit0 = led0.
- tick  out  1  one-cycle display-tick pulse.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset: rst is sampled on clk100mhz rising edge. It overrides everything, including mid-slot operation. State is set to IDLE and the following values are loaded:
  - presc_cnt=0, tick=0, slot_cnt=0
  - gnt=0, busy=0, led=IDLE_PATTERN
  - last=NREQ-1, so requester 0 wins first.
- Prescaler:
  - presc_cnt counts 0..PRESCALE-1 and wraps to 0.
  - tick is registered and equals 1 in the cycle after presc_cnt==PRESCALE-1. The period is exactly PRESCALE cycles.
  - The prescaler free-runs, independent of the FSM.
- Round-robin pick (combinational):
  - The first i with req[i]=1, scanning last+1, last+2, ... modulo NREQ.
  - "Any" is the OR of req.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - led=IDLE_PATTERN, gnt=0.
  - If any: owner<=pick, gnt<=onehot(pick), slot_cnt<=0, go to GRANT.
- GRANT:
  - Each cycle led<=pat[owner], so latency from pat change to led is 1 cycle.
  - On tick, slot_cnt<=slot_cnt+1.
  - Exit to RELEASE when req[owner]==0, or when (tick && slot_cnt==SLOT_TICKS-1). If both occur in the same cycle, exit once.
  - On exit: gnt<=0 and last<=owner.
- RELEASE: one cycle with gnt=0, led held.
  - If any: pick using the updated last, grant it, go to GRANT.
  - Otherwise go to IDLE; led becomes IDLE_PATTERN one cycle later.
- Handshake rules:
  - A source may only drive the LEDs while its gnt=1.
  - Dropping req ends the slot early; gnt falls on the next edge.
  - A source that keeps req high with no competitors is re-granted after exactly one gnt-low cycle.
  - With competitors, the re-grant occurs only after every other requesting source has had a turn.
- Slot timing:
  - The first slot is partial: ticks are counted from the grant edge, not aligned to it.
  - With SLOT_TICKS=1, release occurs at the first tick after the grant.
- Invariants:
  - gnt is always zero or one-hot.
  - busy==|gnt.
  - A req asserted while another source owns the bank waits. There is no preemption.
- Widths:
  - presc_cnt is $clog2(PRESCALE) bits.
  - slot_cnt is $clog2(SLOT_TICKS+1) bits.
  - owner and last are $clog2(NREQ) bits; NREQ=2 uses 1 bit.

Decomposition:
- Package led_arb_pkg: LED_W=8, state enum {IDLE, GRANT, RELEASE}, and the onehot function.
- Sub-module led_tick_gen (parameter PRESCALE; ports clk100mhz, rst, tick). The same codebase reuses it for other LED timing.
- The round-robin pick stays inline in the arbiter.

Test Plan:
Bench uses PRESCALE=4, SLOT_TICKS=2, NREQ=4.
- Reset and tick:
  - Stimulus: rst for 3 cycles, no req.
  - Required: gnt=0, led=8'h00, busy=0; tick pulses every 4 cycles, each 1 cycle wide.
- Single owner:
  - Stimulus: req=4'b0100, pat2=8'hA5.
  - Required: gnt=4'b0100 one cycle after req is seen; led=8'hA5 the following cycle.
  - Required: after 2 ticks, gnt=0 for exactly 1 cycle, then gnt=4'b0100 again.
- Round robin:
  - Stimulus: req=4'b1111 held, patterns 8'h01/02/04/08.
  - Required: grant order 0,1,2,3,0; led follows the matching pattern; exactly one gnt bit high at any time.
- Early release:
  - Stimulus: owner 1 drops req mid-slot while req3=1.
  - Required: gnt1 falls the next edge; after one RELEASE cycle, gnt=4'b1000; last=1.
- Simultaneous drop and expiry:
  - Stimulus: req0 falls in the same cycle as the final tick.
  - Required: a single RELEASE cycle, then IDLE; led=8'h00 one cycle later.
- Reset mid-slot:
  - Stimulus: rst asserted while gnt=4'b0010.
  - Required: next edge gives gnt=0, led=8'h00, presc_cnt=0.
  - Required: after release of rst with req=4'b0011, requester 0 is granted first.
